random_roller: RTL and testbench
================================

RANDOM_ROLLER -- requirements
Module: random_roller

Interface
REQ-001 Parameter OUT_W, default 7, width of the displayed value and of the range input.
REQ-002 Parameter NUM_STEPS, default 15, number of value updates per roll (1..255).
REQ-003 Parameter BASE_DELAY, default 1000000, cycle count between step 0 and step 1.
REQ-004 Parameter DELAY_INC, default 200000, cycles added to the gap after each successive step (deceleration).
REQ-005 Parameter SEED, default 32'h1, generator state after reset.
REQ-006 i_clk  input  1  system clock; all logic on rising edge.
REQ-007 i_rst  input  1  synchronous, active-high reset.
REQ-008 i_start  input  1  level; its rising edge (registered, one-cycle detect) starts or stops a roll.
REQ-009 i_max  input  OUT_W  upper bound of the range; 0 selects 99.
REQ-010 i_force_en  input  1  when high at roll completion, final value is i_force_val.
REQ-011 i_force_val  input  OUT_W  forced final value.
REQ-012 o_value  output  OUT_W  currently displayed value.
REQ-013 o_busy  output  1  high while in ROLL.
REQ-014 o_done  output  1  one-cycle pulse when a roll completes or is stopped.
REQ-015 o_step  output  8  index of the last step taken.

Function
REQ-016 Generator: 32-bit LCG, state <= state*22695477 + 1 (mod 2^32), advancing every cycle in every state.
REQ-017 Sample = (state mod R) + 1, R = (i_max==0) ? 99 : i_max, computed on the state value present in the sampling cycle; result truncated to OUT_W.
REQ-018 FSM states: IDLE, ROLL, HOLD.
REQ-019 IDLE: o_value=0, o_busy=0; start edge -> ROLL, o_step=0, o_value=sample, gap counter=0, gap target=BASE_DELAY.
REQ-020 ROLL: gap counter increments each cycle; when it reaches gap target -> o_value=new sample, o_step+1, counter=0, target += DELAY_INC.
REQ-021 The update in which o_step reaches NUM_STEPS-1 is the final step: o_value = i_force_en ? i_force_val : sample; o_done pulses the next cycle; state -> HOLD.
REQ-022 Start edge in ROLL: roll stops immediately; o_value holds its current value (no force applied); o_done pulses; -> HOLD.
REQ-023 HOLD: o_value, o_step frozen, o_busy=0; start edge -> ROLL with a fresh roll (as REQ-019).
REQ-024 Start edge coincident with final-step update: final step wins; the edge is ignored.
REQ-025 NUM_STEPS=1: roll completes on the entry sample, o_done one cycle after start edge, force applied.
REQ-026 i_max changes mid-roll take effect on the next sample only; displayed value not recomputed.
REQ-027 Gap counter and target are 32 bits; no wrap within legal parameters (BASE_DELAY + NUM_STEPS*DELAY_INC < 2^32).

Reset
REQ-028 i_rst high at a rising edge: state=IDLE, o_value=0, o_busy=0, o_done=0, o_step=0, gap counter=0, generator state=SEED, start-edge register=current i_start (no spurious edge on release).
REQ-029 Reset mid-ROLL aborts without o_done; reset dominates a coincident start edge.

Verification (OUT_W=7, NUM_STEPS=4, BASE_DELAY=4, DELAY_INC=2, SEED=1)
REQ-030 Reset then start edge, i_max=0 -> o_busy=1; updates at steps 0..3 with gaps 4,6,8 cycles; o_done once; all values in 1..99; o_busy=0 in HOLD.
REQ-031 i_max=6, 50 rolls -> every o_value in 1..6, each value seen at least once.
REQ-032 i_force_en=1, i_force_val=42 -> final o_value=42; intermediate values unforced.
REQ-033 Second start edge after step 1 -> o_value frozen at step-1 value, o_step=1, o_done pulse, state HOLD.
REQ-034 i_rst asserted mid-ROLL with i_start held high -> all outputs 0, no o_done, no roll starts on release until i_start falls and rises.
REQ-035 Golden model: LCG from SEED compared cycle-exactly against o_value at each step.

Source files
------------

// File: rtl/random_roller.sv
`default_nettype none
// random_roller: LCG-driven dice roller that updates its displayed value NUM_STEPS
// times with a growing gap between updates, then holds the result.
// Revision: 1.0
module random_roller #(
  parameter int          OUT_W      = 7,
  parameter int          NUM_STEPS  = 15,
  parameter logic [31:0] BASE_DELAY = 32'd1000000,
  parameter logic [31:0] DELAY_INC  = 32'd200000,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [OUT_W-1:0] i_max,
  input  logic             i_force_en,
  input  logic [OUT_W-1:0] i_force_val,
  output logic [OUT_W-1:0] o_value,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_step
);

  localparam logic [7:0]  LAST_STEP = 8'(NUM_STEPS - 1);
  localparam logic [31:0] LCG_MUL   = 32'd22695477;

  typedef enum logic [1:0] {IDLE = 2'd0, ROLL = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             start_q;
  logic             start_edge;
  logic [31:0]      lcg;
  logic [31:0]      gap_cnt, gap_tgt;
  logic [31:0]      range;
  logic [OUT_W-1:0] sample;
  logic [OUT_W-1:0] value_nxt;
  logic [OUT_W-1:0] value;
  logic [7:0]       step;
  logic             done;
  logic             gap_hit;
  logic             begin_roll, advance, finish, stop;

  assign start_edge = i_start & ~start_q;
  assign range      = (i_max == '0) ? 32'd99 : 32'(i_max);
  assign sample     = OUT_W'((lcg % range) + 32'd1);
  assign gap_hit    = (gap_cnt + 32'd1) == gap_tgt;
  // Forcing only applies to the step that completes a roll, never to a stop.
  assign value_nxt  = (finish && i_force_en) ? i_force_val : sample;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    begin_roll = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (start_edge) begin
          begin_roll = 1'b1;
          finish     = (LAST_STEP == 8'd0);
          state_nxt  = (LAST_STEP == 8'd0) ? HOLD : ROLL;
        end
      end
      ROLL: begin
        // The final step outranks a coincident start edge.
        if (gap_hit && ((step + 8'd1) == LAST_STEP)) begin
          advance   = 1'b1;
          finish    = 1'b1;
          state_nxt = HOLD;
        end else if (start_edge) begin
          stop      = 1'b1;
          state_nxt = HOLD;
        end else if (gap_hit) begin
          advance   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_q <= i_start;
      lcg     <= SEED;
      gap_cnt <= 32'd0;
      gap_tgt <= BASE_DELAY;
      value   <= '0;
      step    <= 8'd0;
      done    <= 1'b0;
    end else begin
      start_q <= i_start;
      lcg     <= lcg * LCG_MUL + 32'd1;
      done    <= finish | stop;
      if (begin_roll) begin
        step    <= 8'd0;
        gap_cnt <= 32'd0;
        gap_tgt <= BASE_DELAY;
        value   <= value_nxt;
      end else if (advance) begin
        step    <= step + 8'd1;
        gap_cnt <= 32'd0;
        gap_tgt <= gap_tgt + DELAY_INC;
        value   <= value_nxt;
      end else if (state == ROLL && !stop) begin
        gap_cnt <= gap_cnt + 32'd1;
      end
    end
  end

  assign o_value = value;
  assign o_busy  = (state == ROLL);
  assign o_done  = done;
  assign o_step  = step;

endmodule
`default_nettype wire

// File: tb/tb_random_roller.sv
`default_nettype none
// tb_random_roller: directed checks of random_roller against an LCG reference model.
// Revision: 1.0
module tb_random_roller;
  localparam int          OUT_W      = 7;
  localparam int          NUM_STEPS  = 4;
  localparam logic [31:0] BASE_DELAY = 32'd4;
  localparam logic [31:0] DELAY_INC  = 32'd2;
  localparam logic [31:0] SEED       = 32'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [OUT_W-1:0] max_in;
  logic             force_en;
  logic [OUT_W-1:0] force_val;
  logic [OUT_W-1:0] value;
  logic             busy;
  logic             done;
  logic [7:0]       step;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] m;
  logic [31:0] pre_state;
  int          seen [0:127];

  random_roller #(
    .OUT_W(OUT_W), .NUM_STEPS(NUM_STEPS), .BASE_DELAY(BASE_DELAY),
    .DELAY_INC(DELAY_INC), .SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_max(max_in),
    .i_force_en(force_en), .i_force_val(force_val),
    .o_value(value), .o_busy(busy), .o_done(done), .o_step(step)
  );

  always #5 clk = ~clk;

  // Reference generator advanced once per clock; pre_state is the value seen during the cycle.
  task automatic tick();
    pre_state = m;
    @(posedge clk);
    if (rst) m = SEED;
    else     m = m * 32'd22695477 + 32'd1;
    #1;
  endtask

  function automatic logic [OUT_W-1:0] samp(input logic [31:0] s, input logic [OUT_W-1:0] mx);
    logic [31:0] r;
    r = (mx == 0) ? 32'd99 : {25'd0, mx};
    return OUT_W'((s % r) + 32'd1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic roll_full(input logic fen, input logic [OUT_W-1:0] fval,
                           input logic [OUT_W-1:0] mx, input logic edge_final);
    logic [OUT_W-1:0] expv;
    int               gap;
    int               rng;
    rng       = (mx == 0) ? 99 : int'(mx);
    max_in    = mx;
    force_en  = fen;
    force_val = fval;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    expv      = samp(pre_state, mx);
    chk("s0_value", 32'(value), 32'(expv));
    chk("s0_step", 32'(step), 0);
    chk("s0_busy", 32'(busy), 1);
    chk("s0_done", 32'(done), 0);
    chk("s0_range", 32'(value >= 1 && int'(value) <= rng), 1);
    seen[value]++;
    gap = int'(BASE_DELAY);
    for (int s = 1; s < NUM_STEPS; s++) begin
      for (int c = 1; c < gap; c++) begin
        tick();
        chk("gap_value", 32'(value), 32'(expv));
        chk("gap_done", 32'(done), 0);
      end
      if (s == NUM_STEPS - 1 && edge_final) start = 1'b1;
      tick();
      if (s == NUM_STEPS - 1 && fen) expv = fval;
      else                           expv = samp(pre_state, mx);
      chk("step_value", 32'(value), 32'(expv));
      chk("step_index", 32'(step), s);
      if (s < NUM_STEPS - 1) begin
        chk("step_busy", 32'(busy), 1);
        chk("step_done", 32'(done), 0);
      end else begin
        chk("final_busy", 32'(busy), 0);
        chk("final_done", 32'(done), 1);
      end
      if (!(s == NUM_STEPS - 1 && fen)) begin
        chk("step_range", 32'(value >= 1 && int'(value) <= rng), 1);
        seen[value]++;
      end
      gap += int'(DELAY_INC);
    end
    tick();
    chk("hold_done", 32'(done), 0);
    chk("hold_busy", 32'(busy), 0);
    chk("hold_value", 32'(value), 32'(expv));
    start = 1'b0;
    tick();
  endtask

  initial begin
    logic [OUT_W-1:0] v0, v1;
    for (int i = 0; i < 128; i++) seen[i] = 0;
    rst = 1'b1; start = 1'b0; max_in = '0; force_en = 1'b0; force_val = '0;
    tick(); tick();
    chk("rst_value", 32'(value), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_step", 32'(step), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Full roll over 1..99, then forced final value.
    roll_full(1'b0, '0, '0, 1'b0);
    roll_full(1'b1, 7'd42, '0, 1'b0);
    // Start edge on the final-step cycle must be ignored.
    roll_full(1'b0, '0, 7'd10, 1'b1);

    // Range 1..6 coverage; uneven spacing between rolls varies the generator phase.
    for (int i = 0; i < 128; i++) seen[i] = 0;
    for (int r = 0; r < 50; r++) begin
      roll_full(1'b0, '0, 7'd6, 1'b0);
      for (int k = 0; k < r % 3; k++) tick();
    end
    for (int v = 1; v <= 6; v++) chk("seen_value", 32'(seen[v] > 0), 1);
    chk("seen_out_of_range", 32'(seen[0] + seen[7] + seen[8]), 0);

    // Stop after step 1; range change mid-roll applies only to the next sample.
    max_in = '0; force_en = 1'b1; force_val = 7'd42;
    start = 1'b1; tick(); start = 1'b0;
    v0 = samp(pre_state, '0);
    chk("stop_s0_value", 32'(value), 32'(v0));
    max_in = 7'd3;
    for (int c = 1; c < int'(BASE_DELAY); c++) begin
      tick();
      chk("stop_gap_value", 32'(value), 32'(v0));
    end
    tick();
    v1 = samp(pre_state, 7'd3);
    chk("stop_s1_value", 32'(value), 32'(v1));
    chk("stop_s1_step", 32'(step), 1);
    start = 1'b1; tick();
    chk("stop_value", 32'(value), 32'(v1));
    chk("stop_step", 32'(step), 1);
    chk("stop_done", 32'(done), 1);
    chk("stop_busy", 32'(busy), 0);
    start = 1'b0; tick();
    chk("stop_done_clr", 32'(done), 0);
    for (int c = 0; c < 10; c++) tick();
    chk("hold_frozen_value", 32'(value), 32'(v1));
    chk("hold_frozen_step", 32'(step), 1);
    chk("hold_frozen_busy", 32'(busy), 0);

    // Reset mid-roll with start held high.
    force_en = 1'b0; max_in = '0;
    start = 1'b1; tick(); tick(); tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1; tick();
    chk("midrst_value", 32'(value), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_step", 32'(step), 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("postrst_busy", 32'(busy), 0);
      chk("postrst_done", 32'(done), 0);
      chk("postrst_value", 32'(value), 0);
    end
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("restart_busy", 32'(busy), 1);
    chk("restart_value", 32'(value), 32'(samp(pre_state, '0)));
    chk("restart_step", 32'(step), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
